// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dataMemory two-port arbiter.
// Optional statistics counters are controlled by the macro DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_P0   = 1'b0,
    ARB_AGED = 1'b1
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  // Field widths of a single port request; top-level ADDR_W/DATA_W must not exceed these.
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  function automatic logic addr_in_range(input logic [DMEM_ADDR_W-1:0] addr,
                                         input int unsigned             words);
    return (addr < words);
  endfunction

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Aging counter for the debug/DMA port: counts consecutive refused cycles
// and flags when the port must win the next conflict.
module dmem_arb_age_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req1,
  input  logic i_gnt1,
  output logic o_force_p1
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Next count: clear on grant or idle, otherwise count refusals up to MAX_WAIT.
  always_comb begin
    w_cnt_nxt = r_wait_cnt;
    if (!i_req1 || i_gnt1) begin
      w_cnt_nxt = '0;
    end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
      w_cnt_nxt = r_wait_cnt + CW'(1);
    end
  end

  // Flag on the next value so the FSM is already aged in the cycle after the last refusal.
  assign o_force_p1 = (w_cnt_nxt == CW'(MAX_WAIT));

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port dataMemory.
// Port 0 (CPU) has fixed priority; port 1 (debug/DMA) is force-granted after
// MAX_WAIT refusals. Optional counters enabled by macro DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1029,
  parameter int MAX_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [1:0]            err_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic [31:0]           stat_gnt0_o,
  output logic [31:0]           stat_gnt1_o,
  output logic [31:0]           stat_conf_o
);

  arb_state_t  r_state, w_state_nxt;
  dmem_req_t   w_req [2];
  dmem_req_t   w_win;
  logic [1:0]  w_gnt;
  logic        w_any;
  logic        w_oor;
  logic        w_force_p1;
  logic [1:0]  r_rvalid;
  logic [1:0]  r_err;
  logic [DATA_W-1:0] r_rdata;

  // Unpack the flat per-port buses into request records.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      w_req[p].we    = we_i[p];
      w_req[p].addr  = DMEM_ADDR_W'(addr_i[p*ADDR_W +: ADDR_W]);
      w_req[p].wdata = DMEM_DATA_W'(wdata_i[p*DATA_W +: DATA_W]);
    end
  end

  // Grant: single requester wins outright; conflicts resolved by FSM state.
  always_comb begin
    w_gnt = '0;
    if (!reset) begin
      if (req_i == 2'b11) begin
        w_gnt = (r_state == ARB_AGED) ? 2'b10 : 2'b01;
      end else begin
        w_gnt = req_i;
      end
    end
  end

  // Winner mux and memory-side controls; out-of-range accesses leave memory untouched.
  always_comb begin
    w_any       = |w_gnt;
    w_win       = w_gnt[PORT_DBG] ? w_req[PORT_DBG] : w_req[PORT_CPU];
    w_oor       = !addr_in_range(w_win.addr, MEM_WORDS);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    if (w_any) begin
      mem_addr_o  = ADDR_W'(w_win.addr);
      mem_wdata_o = DATA_W'(w_win.wdata);
      mem_we_o    = w_win.we & ~w_oor;
      mem_re_o    = ~w_win.we & ~w_oor;
    end
  end

  assign gnt_o = w_gnt;

  dmem_arb_age_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_req1     (req_i[PORT_DBG]),
    .i_gnt1     (w_gnt[PORT_DBG]),
    .o_force_p1 (w_force_p1)
  );

  // FSM next state: age into ARB_AGED, return after one port 1 grant or withdrawal.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_P0:   if (w_force_p1) w_state_nxt = ARB_AGED;
      ARB_AGED: if (w_gnt[PORT_DBG] || !req_i[PORT_DBG]) w_state_nxt = ARB_P0;
      default:  w_state_nxt = ARB_P0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_P0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response register: one-cycle ack for every grant, read data only for in-range reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & {2{w_oor}};
      r_rdata  <= mem_re_o ? mem_rdata_i : '0;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_gnt0;
  logic [31:0] r_stat_gnt1;
  logic [31:0] r_stat_conf;

  // Saturating grant and conflict counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_gnt0 <= '0;
      r_stat_gnt1 <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_gnt[PORT_CPU] && (r_stat_gnt0 != '1)) r_stat_gnt0 <= r_stat_gnt0 + 32'd1;
      if (w_gnt[PORT_DBG] && (r_stat_gnt1 != '1)) r_stat_gnt1 <= r_stat_gnt1 + 32'd1;
      if ((req_i == 2'b11) && (r_stat_conf != '1)) r_stat_conf <= r_stat_conf + 32'd1;
    end
  end

  assign stat_gnt0_o = r_stat_gnt0;
  assign stat_gnt1_o = r_stat_gnt1;
  assign stat_conf_o = r_stat_conf;
`else
  assign stat_gnt0_o = '0;
  assign stat_gnt1_o = '0;
  assign stat_conf_o = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural dataMemory
// (combinational read, write and clear at the rising edge, resetN = ~reset).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_i, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [1:0]  gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_we_o, mem_re_o;
  logic [31:0] stat_gnt0_o, stat_gnt1_o, stat_conf_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .MEM_WORDS (1029),
    .MAX_WAIT  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_re_o    (mem_re_o),
    .mem_rdata_i (mem_rdata_i),
    .stat_gnt0_o (stat_gnt0_o),
    .stat_gnt1_o (stat_gnt1_o),
    .stat_conf_o (stat_conf_o)
  );

  // Behavioural dataMemory.
  logic [31:0] mem [0:1028];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1029; i++) mem[i] <= '0;
    end else if (mem_we_o && (mem_addr_o < 32'd1029)) begin
      mem[mem_addr_o[10:0]] <= mem_wdata_o;
    end
  end
  assign mem_rdata_i = (mem_addr_o < 32'd1029) ? mem[mem_addr_o[10:0]] : 32'h0;

  typedef struct {
    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] a0, a1, wd0, wd1;
    logic [1:0]  gnt;
    logic        mwe, mre;
    logic [31:0] maddr;
    logic [1:0]  rv, er;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(logic rst, logic [1:0] req, logic [1:0] we,
                              logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] wd0, logic [31:0] wd1,
                              logic [1:0] gnt, logic mwe, logic mre, logic [31:0] maddr,
                              logic [1:0] rv, logic [1:0] er, logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.gnt = gnt; v.mwe = mwe; v.mre = mre; v.maddr = maddr; v.rv = rv; v.er = er; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1);
    reset   = rst;
    req_i   = req;
    we_i    = we;
    addr_i  = {a1, a0};
    wdata_i = {wd1, wd0};
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, then P0 write/read, P1 out-of-range write, OOR read, contention.
    vt[0] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0,                     2'b00, 0, 0, 0,    2'b00, 2'b00, 32'h0);
    vt[1] = mk(0, 2'b01, 2'b01, 5, 0, 32'hDEAD_BEEF, 0,         2'b01, 1, 0, 5,    2'b00, 2'b00, 32'h0);
    vt[2] = mk(0, 2'b01, 2'b00, 5, 0, 0, 0,                     2'b01, 0, 1, 5,    2'b01, 2'b00, 32'h0);
    vt[3] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,                     2'b00, 0, 0, 0,    2'b01, 2'b00, 32'hDEAD_BEEF);
    vt[4] = mk(0, 2'b10, 2'b10, 0, 1028, 0, 32'hCAFE_0001,      2'b10, 1, 0, 1028, 2'b00, 2'b00, 32'h0);
    vt[5] = mk(0, 2'b10, 2'b10, 0, 1029, 0, 32'h1234,           2'b10, 0, 0, 1029, 2'b10, 2'b00, 32'h0);
    vt[6] = mk(0, 2'b10, 2'b00, 0, 1028, 0, 0,                  2'b10, 0, 1, 1028, 2'b10, 2'b10, 32'h0);
    vt[7] = mk(0, 2'b01, 2'b00, 2000, 0, 0, 0,                  2'b01, 0, 0, 2000, 2'b10, 2'b00, 32'hCAFE_0001);
    vt[8] = mk(0, 2'b01, 2'b01, 10, 0, 32'hA0A0_A0A0, 0,        2'b01, 1, 0, 10,   2'b01, 2'b01, 32'h0);
    vt[9] = mk(0, 2'b10, 2'b10, 0, 20, 0, 32'hB1B1_B1B1,        2'b10, 1, 0, 20,   2'b01, 2'b00, 32'h0);
    // Dual read requests: P0 four times, then P1 on the fifth, repeating.
    for (int k = 0; k < 10; k++) begin
      logic        p1, pp1;
      logic [1:0]  prv;
      logic [31:0] prd;
      p1  = ((k % 5) == 4);
      pp1 = (k > 0) && (((k - 1) % 5) == 4);
      prv = (k == 0) ? 2'b10 : (pp1 ? 2'b10 : 2'b01);
      prd = (k == 0) ? 32'h0 : (pp1 ? 32'hB1B1_B1B1 : 32'hA0A0_A0A0);
      vt[10+k] = mk(0, 2'b11, 2'b00, 10, 20, 0, 0,
                    p1 ? 2'b10 : 2'b01, 0, 1, p1 ? 32'd20 : 32'd10, prv, 2'b00, prd);
    end
    vt[20] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,                    2'b00, 0, 0, 0,    2'b10, 2'b00, 32'hB1B1_B1B1);

    reset = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    tick();
    tick();

    for (int i = 0; i < 21; i++) begin
      drive(vt[i].rst, vt[i].req, vt[i].we, vt[i].a0, vt[i].a1, vt[i].wd0, vt[i].wd1);
      chk($sformatf("v%0d gnt", i),    {30'b0, gnt_o},    {30'b0, vt[i].gnt});
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we_o}, {31'b0, vt[i].mwe});
      chk($sformatf("v%0d mem_re", i), {31'b0, mem_re_o}, {31'b0, vt[i].mre});
      chk($sformatf("v%0d mem_addr", i), mem_addr_o,      vt[i].maddr);
      chk($sformatf("v%0d rvalid", i), {30'b0, rvalid_o}, {30'b0, vt[i].rv});
      chk($sformatf("v%0d err", i),    {30'b0, err_o},    {30'b0, vt[i].er});
      chk($sformatf("v%0d rdata", i),  rdata_o,           vt[i].rd);
      tick();
    end

    // Aging restart: 3 refusals, P1 withdraws, then 4 fresh refusals before P1 wins.
    for (int k = 0; k < 3; k++) begin
      drive(0, 2'b11, 2'b00, 10, 20, 0, 0);
      chk($sformatf("age pre%0d gnt", k), {30'b0, gnt_o}, 32'd1);
      tick();
    end
    drive(0, 2'b01, 2'b00, 10, 20, 0, 0);
    chk("age drop gnt", {30'b0, gnt_o}, 32'd1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 2'b11, 2'b00, 10, 20, 0, 0);
      chk($sformatf("age post%0d gnt", k), {30'b0, gnt_o}, (k == 4) ? 32'd2 : 32'd1);
      tick();
    end
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_conf", stat_conf_o, 32'd18);
    chk("stat_gnt0", stat_gnt0_o, 32'd20);
    chk("stat_gnt1", stat_gnt1_o, 32'd7);
`else
    chk("stat_conf", stat_conf_o, 32'd0);
    chk("stat_gnt0", stat_gnt0_o, 32'd0);
    chk("stat_gnt1", stat_gnt1_o, 32'd0);
`endif
    tick();

    // Reset coincident with a P0 write to addr 7.
    drive(1, 2'b01, 2'b01, 7, 0, 32'h7777_7777, 0);
    chk("rst gnt",    {30'b0, gnt_o},    32'd0);
    chk("rst mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst mem_re", {31'b0, mem_re_o}, 32'd0);
    tick();
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("post-rst rvalid",    {30'b0, rvalid_o}, 32'd0);
    chk("post-rst err",       {30'b0, err_o},    32'd0);
    chk("post-rst stat_conf", stat_conf_o,       32'd0);
    chk("post-rst stat_gnt0", stat_gnt0_o,       32'd0);
    tick();
    drive(0, 2'b01, 2'b00, 7, 0, 0, 0);
    chk("rd7 gnt",    {30'b0, gnt_o},    32'd1);
    chk("rd7 mem_re", {31'b0, mem_re_o}, 32'd1);
    tick();
    drive(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("rd7 rvalid", {30'b0, rvalid_o}, 32'd1);
    chk("rd7 rdata",  rdata_o,           32'd0);
    chk("rd7 err",    {30'b0, err_o},    32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
